// File: rtl/ycbcr_pkg.sv
// Shared constants and types for the YCbCr colour-space blocks.
// Forward (RGB->YCbCr) and inverse (YCbCr->RGB) coefficients are scaled by 256.
package ycbcr_pkg;

  // Forward coefficients (RGB -> YCbCr), x256
  localparam int FWD_Y_R  = 77;
  localparam int FWD_Y_G  = 150;
  localparam int FWD_Y_B  = 29;
  localparam int FWD_CB_R = 43;
  localparam int FWD_CB_G = 85;
  localparam int FWD_CR_G = 107;

  // Inverse coefficients (YCbCr -> RGB), x256
  localparam int INV_R_CR = 359;
  localparam int INV_G_CB = 88;
  localparam int INV_G_CR = 183;
  localparam int INV_B_CB = 454;

  // Chroma offset for 8-bit full-range Cb/Cr
  localparam int CHROMA_OFS = 128;

  // Number of register stages between pre_* and post_*
  localparam int PIPE_DEPTH = 3;

  // Signed accumulator wide enough for 256*Y plus any chroma product
  typedef logic signed [18:0] acc_t;

  // Remove the 128 offset from an 8-bit chroma sample: result in [-128, 127]
  function automatic logic signed [8:0] chroma_ofs(input logic [7:0] c);
    return $signed({1'b0, c}) - 9'sd128;
  endfunction

  // Sign-extend a 9-bit chroma difference to accumulator width
  function automatic acc_t sext9(input logic signed [8:0] v);
    return {{10{v[8]}}, v};
  endfunction

endpackage

// File: rtl/ycbcr_clamp8.sv
// Combinational clamp of a signed 19-bit x256 sum to an 8-bit channel value.
// clamped is high when the sum was below 0 or at/above 65536.
module ycbcr_clamp8
  import ycbcr_pkg::*;
(
  input  logic signed [18:0] sum,
  output logic [7:0]         val,
  output logic               clamped
);

  // Negative sums go to 0, sums of 65536 and above go to 255, else take [15:8]
  always_comb begin
    val     = sum[15:8];
    clamped = 1'b0;
    if (sum[18]) begin
      val     = 8'h00;
      clamped = 1'b1;
    end else if (sum[17:16] != 2'b00) begin
      val     = 8'hFF;
      clamped = 1'b1;
    end
  end

endmodule

// File: rtl/ycbcr2rgb_disp.sv
// YCbCr 4:4:4 (BT.601 full range) to RGB565 converter for the display path.
// Three register stages: products, sums, clamp+pack. Sync signals ride along
// in matching 3-bit shift registers.
// Stream semantics: one pixel per clk, de qualifies the pixel, there is no
// ready/backpressure; data is computed every cycle regardless of de.
// Optional build macro YCBCR2RGB_SAT_CNT_EN adds a per-frame clamp counter
// (sat_cnt), latched on each rising edge of post_frame_vsync.
module ycbcr2rgb_disp
  import ycbcr_pkg::*;
#(
  parameter bit RND_EN     = 1'b1,
  parameter bit BLANK_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pre_frame_vsync,
  input  logic        pre_frame_hsync,
  input  logic        pre_frame_de,
  input  logic [7:0]  img_y,
  input  logic [7:0]  img_cb,
  input  logic [7:0]  img_cr,
  output logic        post_frame_vsync,
  output logic        post_frame_hsync,
  output logic        post_frame_de,
  output logic [4:0]  img_red,
  output logic [5:0]  img_green,
  output logic [4:0]  img_blue
`ifdef YCBCR2RGB_SAT_CNT_EN
  ,
  output logic [19:0] sat_cnt
`endif
);

  localparam acc_t RND_ADD = RND_EN ? acc_t'(128) : acc_t'(0);

  logic signed [8:0] cb_d, cr_d;
  acc_t y_s1, r_cr_s1, g_cb_s1, g_cr_s1, b_cb_s1;
  acc_t r_s2, g_s2, b_s2;
  logic [7:0] r8, g8, b8;
  logic r_clip, g_clip, b_clip;
  logic [4:0] red_s3, blue_s3;
  logic [5:0] green_s3;
  logic [PIPE_DEPTH-1:0] vs_sr, hs_sr, de_sr;
  logic blank;
  logic unused_lsbs;

  assign cb_d = chroma_ofs(img_cb);
  assign cr_d = chroma_ofs(img_cr);

  // Stage 1: scaled luma and the four chroma products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_s1    <= '0;
      r_cr_s1 <= '0;
      g_cb_s1 <= '0;
      g_cr_s1 <= '0;
      b_cb_s1 <= '0;
    end else begin
      y_s1    <= acc_t'({3'b000, img_y, 8'h00});
      r_cr_s1 <= sext9(cr_d) * acc_t'(INV_R_CR);
      g_cb_s1 <= sext9(cb_d) * acc_t'(INV_G_CB);
      g_cr_s1 <= sext9(cr_d) * acc_t'(INV_G_CR);
      b_cb_s1 <= sext9(cb_d) * acc_t'(INV_B_CB);
    end
  end

  // Stage 2: per-channel sums with optional half-LSB rounding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2 <= '0;
      g_s2 <= '0;
      b_s2 <= '0;
    end else begin
      r_s2 <= y_s1 + r_cr_s1 + RND_ADD;
      g_s2 <= y_s1 - g_cb_s1 - g_cr_s1 + RND_ADD;
      b_s2 <= y_s1 + b_cb_s1 + RND_ADD;
    end
  end

  ycbcr_clamp8 u_clamp_r (.sum(r_s2), .val(r8), .clamped(r_clip));
  ycbcr_clamp8 u_clamp_g (.sum(g_s2), .val(g8), .clamped(g_clip));
  ycbcr_clamp8 u_clamp_b (.sum(b_s2), .val(b8), .clamped(b_clip));

  // Stage 3: clamped 8-bit channels truncated into RGB565
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_s3   <= '0;
      green_s3 <= '0;
      blue_s3  <= '0;
    end else begin
      red_s3   <= r8[7:3];
      green_s3 <= g8[7:2];
      blue_s3  <= b8[7:3];
    end
  end

  // Sync delay lines matching the three data stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sr <= '0;
      hs_sr <= '0;
      de_sr <= '0;
    end else begin
      vs_sr <= {vs_sr[PIPE_DEPTH-2:0], pre_frame_vsync};
      hs_sr <= {hs_sr[PIPE_DEPTH-2:0], pre_frame_hsync};
      de_sr <= {de_sr[PIPE_DEPTH-2:0], pre_frame_de};
    end
  end

  assign post_frame_vsync = vs_sr[PIPE_DEPTH-1];
  assign post_frame_hsync = hs_sr[PIPE_DEPTH-1];
  assign post_frame_de    = de_sr[PIPE_DEPTH-1];

  // Blanking is combinational on the delayed de so it tracks it exactly
  assign blank     = BLANK_ZERO & ~post_frame_de;
  assign img_red   = blank ? 5'd0 : red_s3;
  assign img_green = blank ? 6'd0 : green_s3;
  assign img_blue  = blank ? 5'd0 : blue_s3;

`ifdef YCBCR2RGB_SAT_CNT_EN
  logic        clip_s3;
  logic        vs_q;
  logic        hit;
  logic        vs_rise;
  logic [19:0] clip_acc;

  assign hit     = post_frame_de & clip_s3;
  assign vs_rise = post_frame_vsync & ~vs_q;

  // Clamp flag aligned with stage-3 data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clip_s3 <= 1'b0;
    else        clip_s3 <= r_clip | g_clip | b_clip;
  end

  // Per-frame clamp counter, latched and restarted on each vsync rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q     <= 1'b0;
      clip_acc <= '0;
      sat_cnt  <= '0;
    end else begin
      vs_q <= post_frame_vsync;
      if (vs_rise) begin
        sat_cnt  <= clip_acc;
        clip_acc <= hit ? 20'd1 : 20'd0;
      end else if (hit && clip_acc != 20'hFFFFF) begin
        clip_acc <= clip_acc + 20'd1;
      end
    end
  end

  assign unused_lsbs = ^{r8[2:0], g8[1:0], b8[2:0]};
`else
  assign unused_lsbs = ^{r8[2:0], g8[1:0], b8[2:0], r_clip, g_clip, b_clip};
`endif

endmodule

// File: tb/tb_ycbcr2rgb_disp.sv
// Bench for ycbcr2rgb_disp: two instances share the stimulus, one with
// rounding and blanking (defaults), one truncating and passing data through.
module tb_ycbcr2rgb_disp;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       vs = 1'b0, hs = 1'b0, de = 1'b0;
  logic [7:0] img_y = '0, img_cb = '0, img_cr = '0;

  logic       vs_a, hs_a, de_a, vs_b, hs_b, de_b;
  logic [4:0] red_a, blue_a, red_b, blue_b;
  logic [5:0] green_a, green_b;
`ifdef YCBCR2RGB_SAT_CNT_EN
  logic [19:0] sat_a, sat_b;
`endif

  ycbcr2rgb_disp dut_a (
    .clk(clk), .rst_n(rst_n),
    .pre_frame_vsync(vs), .pre_frame_hsync(hs), .pre_frame_de(de),
    .img_y(img_y), .img_cb(img_cb), .img_cr(img_cr),
    .post_frame_vsync(vs_a), .post_frame_hsync(hs_a), .post_frame_de(de_a),
    .img_red(red_a), .img_green(green_a), .img_blue(blue_a)
`ifdef YCBCR2RGB_SAT_CNT_EN
    , .sat_cnt(sat_a)
`endif
  );

  ycbcr2rgb_disp #(.RND_EN(1'b0), .BLANK_ZERO(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .pre_frame_vsync(vs), .pre_frame_hsync(hs), .pre_frame_de(de),
    .img_y(img_y), .img_cb(img_cb), .img_cr(img_cr),
    .post_frame_vsync(vs_b), .post_frame_hsync(hs_b), .post_frame_de(de_b),
    .img_red(red_b), .img_green(green_b), .img_blue(blue_b)
`ifdef YCBCR2RGB_SAT_CNT_EN
    , .sat_cnt(sat_b)
`endif
  );

  // ---------------- vector table (hand-computed) ----------------
  logic [7:0]  vy [9];
  logic [7:0]  vcb[9];
  logic [7:0]  vcr[9];
  logic [15:0] e_rnd[9];
  logic [15:0] e_trn[9];
  logic        vclamp[9];

  function automatic logic [15:0] pk(input int r, input int g, input int b);
    return {5'(r), 6'(g), 5'(b)};
  endfunction

  task automatic set_vec(input int i, input int y, input int cb, input int cr,
                         input logic [15:0] er, input logic [15:0] et, input logic cl);
    vy[i] = 8'(y); vcb[i] = 8'(cb); vcr[i] = 8'(cr);
    e_rnd[i] = er; e_trn[i] = et; vclamp[i] = cl;
  endtask

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [15:0] exp0_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int clamp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference sync delay: inputs as seen three sampling edges earlier
  logic [2:0] hist[3];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist[0] <= '0; hist[1] <= '0; hist[2] <= '0;
    end else begin
      hist[0] <= {vs, hs, de};
      hist[1] <= hist[0];
      hist[2] <= hist[1];
    end
  end

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_a", 32'({vs_a, hs_a, de_a, red_a, green_a, blue_a}), 32'd0);
      check("rst_out_b", 32'({vs_b, hs_b, de_b, red_b, green_b, blue_b}), 32'd0);
    end else begin
      check("sync_a", 32'({vs_a, hs_a, de_a}), 32'(hist[2]));
      check("sync_b", 32'({vs_b, hs_b, de_b}), 32'(hist[2]));
      if (de_a) begin
        if (exp_q.size() == 0) check("unexpected_px_a", 32'd1, 32'd0);
        else check("pix_rnd", 32'({red_a, green_a, blue_a}), 32'(exp_q.pop_front()));
      end else begin
        check("blank_a", 32'({red_a, green_a, blue_a}), 32'd0);
      end
      if (de_b) begin
        if (exp0_q.size() == 0) check("unexpected_px_b", 32'd1, 32'd0);
        else check("pix_trn", 32'({red_b, green_b, blue_b}), 32'(exp0_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic rv, input logic v, input logic h,
                       input logic d, input int idx);
    @(posedge clk);
    #1;
    if (!rv && rst_n) begin
      exp_q.delete();
      exp0_q.delete();
    end
    rst_n  = rv;
    vs     = v;
    hs     = h;
    de     = d;
    img_y  = vy[idx];
    img_cb = vcb[idx];
    img_cr = vcr[idx];
    if (rv && d) begin
      exp_q.push_back(e_rnd[idx]);
      exp0_q.push_back(e_trn[idx]);
      clamp_cnt += int'(vclamp[idx]);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 1'b0, 1'b0, 5);
  endtask

`ifdef YCBCR2RGB_SAT_CNT_EN
  task automatic frame_mark();
    int want;
    want = clamp_cnt;
    clamp_cnt = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5);
    idle(6);
    check("sat_cnt_a", 32'(sat_a), 32'(want));
    check("sat_cnt_b", 32'(sat_b), 32'(want));
  endtask
`else
  task automatic frame_mark();
    clamp_cnt = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5);
    idle(6);
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    //           idx  Y    Cb   Cr   rounded          truncated        clamp
    set_vec(0, 128, 128, 128, pk(16, 32, 16), pk(16, 32, 16), 1'b0);
    set_vec(1, 255, 128, 255, pk(31, 41, 31), pk(31, 41, 31), 1'b1);
    set_vec(2,   0,   0,   0, pk( 0, 34,  0), pk( 0, 33,  0), 1'b1);
    set_vec(3, 100, 128, 129, pk(12, 24, 12), pk(12, 24, 12), 1'b0);
    set_vec(4, 255, 255, 128, pk(31, 52, 31), pk(31, 52, 31), 1'b1);
    set_vec(5,   0, 128, 128, pk( 0,  0,  0), pk( 0,  0,  0), 1'b0);
    set_vec(6,  16,  90, 200, pk(14,  0,  0), pk(14,  0,  0), 1'b1);
    set_vec(7, 200,  60, 100, pk(20, 60,  9), pk(20, 60,  9), 1'b0);
    set_vec(8, 133, 128, 130, pk(17, 33, 16), pk(16, 32, 16), 1'b0);

    // Hold reset for a few cycles, then release
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 5);
    idle(4);

    // Frame start, then one line of back-to-back pixels
    frame_mark();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5);
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b0, 1'b1, i);
    idle(4);
    frame_mark();

    // Latency of a single pixel, bounded wait
    lat = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 0);
    for (int c = 1; c <= 8; c++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 5);
      if (de_a) begin
        lat = c;
        break;
      end
    end
    check("latency", 32'(lat), 32'd3);
    idle(4);

    // Single-cycle de pulses with hsync/vsync toggling
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, (i % 3) == 0, (i % 2) == 0, 1'b1, i);
      drive(1'b1, (i % 3) == 1, 1'b0, 1'b0, 5);
    end
    idle(4);

    // Continuous stream with a 2-cycle reset pulse mid-line
    for (int i = 0; i < 20; i++) begin
      drive(!(i == 6 || i == 7), 1'b0, 1'b0, 1'b1, i % 9);
    end
    idle(6);

    check("drain_a", 32'(exp_q.size()), 32'd0);
    check("drain_b", 32'(exp0_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
